// File: rtl/cp0_except_unit.sv
// cp0_except_unit: MEM-stage exception resolver with Count/Compare/Status/Cause/EPC and mfc0/mtc0
module cp0_except_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [5:0]  int_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [4:0]  cp0_raddr_i,
  output logic [31:0] cp0_rdata_o,
  output logic [31:0] excepttype_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);
  logic [31:0] count, compare, status, cause, epc;
  logic timer, int_take, exc, eret, we;
  logic [4:0] exc_code;
  logic unused_ok;
  assign unused_ok = ^{excepttype_i[31:13], excepttype_i[11:10], excepttype_i[7:0]};
  assign int_take = valid_i & status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
  always_comb begin
    excepttype_o = !rst_n ? 32'h0 :
                   int_take ? 32'h1 :
                   excepttype_i[8] ? 32'h8 :
                   excepttype_i[9] ? 32'ha :
                   excepttype_i[12] ? 32'he : 32'h0;
    cp0_rdata_o = cp0_raddr_i == 5'd9  ? count :
                  cp0_raddr_i == 5'd11 ? compare :
                  cp0_raddr_i == 5'd12 ? status :
                  cp0_raddr_i == 5'd13 ? cause :
                  cp0_raddr_i == 5'd14 ? epc : 32'h0;
  end
  assign flush_o = excepttype_o != 32'h0;
  assign eret = excepttype_o == 32'he;
  assign exc = flush_o & ~eret;
  assign exc_code = excepttype_o == 32'h1 ? 5'd0 : excepttype_o[4:0];
  assign new_pc_o = eret ? epc : EXC_VECTOR;
  assign we = cp0_we_i & ~flush_o;
  assign status_o = status;
  assign cause_o = cause;
  assign epc_o = epc;
  assign timer_int_o = timer;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'h0;
      compare <= 32'h0;
      status <= STATUS_RST;
      cause <= 32'h0;
      epc <= 32'h0;
      timer <= 1'b0;
    end else begin
      count <= (we && cp0_waddr_i == 5'd9) ? cp0_wdata_i : count + 32'd1;
      if (we && cp0_waddr_i == 5'd11) compare <= cp0_wdata_i;
      timer <= (we && cp0_waddr_i == 5'd11) ? 1'b0 : timer | (count == compare && compare != 32'h0);
      if (we && cp0_waddr_i == 5'd12) status <= cp0_wdata_i;
      if (we && cp0_waddr_i == 5'd14) epc <= cp0_wdata_i;
      if (we && cp0_waddr_i == 5'd13) cause[9:8] <= cp0_wdata_i[9:8];
      cause[15:10] <= {int_i[5] | timer, int_i[4:0]};
      if (exc) begin
        epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
        cause[31] <= in_delayslot_i;
        cause[6:2] <= exc_code;
        status[1] <= 1'b1;
      end
      if (eret) status[1] <= 1'b0;
    end
  end
endmodule
